// File: rtl/rr_event_dispatcher.sv
// rr_event_dispatcher
// Keeps a saturating pending count per event channel and hands a single
// shared command resource to the channels in round-robin order, one
// outstanding command at a time.
// Optional build macro RR_EVENT_DISPATCHER_TIMEOUT_EN adds a completion
// watchdog. Without it, WAIT_DONE waits for done indefinitely and the
// timeout output is tied low.
module rr_event_dispatcher #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 4,
   parameter int TIMEOUT    = 1023,
   localparam int LB_DATA_WIDTH = $clog2(DATA_WIDTH)
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [LB_DATA_WIDTH-1:0] ev_index,
   input  logic                     ev_valid,
   output logic                     ev_ready,
   output logic [LB_DATA_WIDTH-1:0] cmd_index,
   output logic                     cmd_valid,
   input  logic                     cmd_ready,
   input  logic                     done,
   output logic [DATA_WIDTH-1:0]    pending,
   output logic                     overflow,
   output logic                     bad_index,
   output logic                     timeout
);

   localparam logic [CNT_WIDTH-1:0]     CNT_MAX  = '1;
   localparam logic [LB_DATA_WIDTH-1:0] LAST_IDX = LB_DATA_WIDTH'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ISSUE     = 2'd1,
      S_WAIT_DONE = 2'd2
   } state_t;

   state_t                     state_q, state_d;
   logic [LB_DATA_WIDTH-1:0]   cmd_index_q, cmd_index_d;
   logic [LB_DATA_WIDTH-1:0]   ptr_q, ptr_d;
   logic                       overflow_q, overflow_d;
   logic                       bad_index_q, bad_index_d;

   logic                       ev_accept;
   logic                       idx_ok;
   logic                       dec_fire;
   logic                       wd_expire;
   logic                       found;
   logic [LB_DATA_WIDTH-1:0]   sel_idx;
   logic [DATA_WIDTH-1:0]      pend_vec;
   logic [DATA_WIDTH-1:0]      sat_hit;

   // Events are accepted whenever the block is out of reset.
   assign ev_ready  = rstn;
   assign ev_accept = ev_valid & rstn;

   // An index is only out of range when DATA_WIDTH is not a power of two.
   if ((1 << LB_DATA_WIDTH) == DATA_WIDTH) begin : g_idx_full
      assign idx_ok = 1'b1;
   end else begin : g_idx_part
      assign idx_ok = ({1'b0, ev_index} < (LB_DATA_WIDTH + 1)'(DATA_WIDTH));
   end

   // Per-channel saturating counters. A simultaneous increment and
   // decrement on the same channel cancel out and never report overflow.
   for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_chan
      logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
      logic                 inc, dec;

      assign inc = ev_accept && idx_ok && (ev_index == LB_DATA_WIDTH'(gi));
      assign dec = dec_fire && (cmd_index_q == LB_DATA_WIDTH'(gi));

      // Next count: +1 unless saturated, -1 on completion, hold if both.
      always_comb begin
         cnt_d = cnt_q;
         if (inc && !dec) begin
            if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
         end else if (dec && !inc) begin
            cnt_d = cnt_q - 1'b1;
         end
      end

      // Counter register.
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      assign sat_hit[gi]  = inc && !dec && (cnt_q == CNT_MAX);
      assign pend_vec[gi] = |cnt_q;
   end

   assign pending = pend_vec;

   // Round-robin search: first nonzero channel starting at ptr, wrapping.
   always_comb begin
      int                       j;
      logic [LB_DATA_WIDTH-1:0] jj;
      found   = 1'b0;
      sel_idx = '0;
      j       = 0;
      jj      = '0;
      for (int k = 0; k < DATA_WIDTH; k++) begin
         j = int'(ptr_q) + k;
         if (j >= DATA_WIDTH) begin
            j = j - DATA_WIDTH;
         end
         jj = LB_DATA_WIDTH'(j);
         if (!found && pend_vec[jj]) begin
            found   = 1'b1;
            sel_idx = jj;
         end
      end
   end

   // FSM next state, command latch, pointer advance and completion decode.
   always_comb begin
      state_d     = state_q;
      cmd_index_d = cmd_index_q;
      ptr_d       = ptr_q;
      dec_fire    = 1'b0;
      cmd_valid   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               cmd_index_d = sel_idx;
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cmd_valid = 1'b1;
            if (cmd_ready) begin
               state_d = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (done || wd_expire) begin
               dec_fire = 1'b1;
               ptr_d    = (cmd_index_q == LAST_IDX) ? '0 : cmd_index_q + 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // FSM state, command index and round-robin pointer registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         cmd_index_q <= '0;
         ptr_q       <= '0;
      end else begin
         state_q     <= state_d;
         cmd_index_q <= cmd_index_d;
         ptr_q       <= ptr_d;
      end
   end

   assign cmd_index = cmd_index_q;

   // Status pulses are raised for one cycle after the causing edge.
   always_comb begin
      overflow_d  = |sat_hit;
      bad_index_d = ev_accept && !idx_ok;
   end

   // Status pulse registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         overflow_q  <= 1'b0;
         bad_index_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         bad_index_q <= bad_index_d;
      end
   end

   assign overflow  = overflow_q;
   assign bad_index = bad_index_q;

`ifdef RR_EVENT_DISPATCHER_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);

   logic [WD_W-1:0] wd_q, wd_d;
   logic            timeout_q, timeout_d;

   // Watchdog counts WAIT_DONE cycles; it sits at zero elsewhere, so it
   // starts fresh on every entry. Done in the expiry cycle wins.
   always_comb begin
      wd_expire = (state_q == S_WAIT_DONE) && (wd_q == WD_W'(TIMEOUT - 1));
      timeout_d = wd_expire && !done;
      wd_d      = '0;
      if ((state_q == S_WAIT_DONE) && !wd_expire && !done) begin
         wd_d = wd_q + 1'b1;
      end
   end

   // Watchdog counter and timeout pulse registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         wd_q      <= wd_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign wd_expire = 1'b0;
   assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_event_dispatcher.sv
// Scoreboard bench for rr_event_dispatcher: expected grants are queued as
// stimulus is issued; a negedge monitor pops and compares on each command
// handshake and counts status pulses.
module tb_rr_event_dispatcher;

   logic       clk;
   logic       rstn;
   logic [2:0] ev_index;
   logic       ev_valid;
   logic       ev_ready;
   logic [2:0] cmd_index;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       done;
   logic [7:0] pending;
   logic       overflow;
   logic       bad_index;
   logic       timeout;

   // second instance with a non-power-of-two channel count
   logic [2:0] ev6_index;
   logic       ev6_valid;
   logic       ev6_ready;
   logic [2:0] cmd6_index;
   logic       cmd6_valid;
   logic       cmd6_ready;
   logic       done6;
   logic [5:0] pending6;
   logic       overflow6;
   logic       bad6;
   logic       timeout6;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_q[$];
   int ov_cnt   = 0;
   int to_cnt   = 0;
   int bad6_cnt = 0;
   logic hs_pending = 1'b0;
   logic auto_en    = 1'b0;
   logic man_done   = 1'b0;

   rr_event_dispatcher #(.DATA_WIDTH(8), .CNT_WIDTH(4), .TIMEOUT(10)) u_dut (
      .clk(clk), .rstn(rstn), .ev_index(ev_index), .ev_valid(ev_valid),
      .ev_ready(ev_ready), .cmd_index(cmd_index), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready), .done(done), .pending(pending),
      .overflow(overflow), .bad_index(bad_index), .timeout(timeout)
   );

   rr_event_dispatcher #(.DATA_WIDTH(6), .CNT_WIDTH(4), .TIMEOUT(10)) u_dut6 (
      .clk(clk), .rstn(rstn), .ev_index(ev6_index), .ev_valid(ev6_valid),
      .ev_ready(ev6_ready), .cmd_index(cmd6_index), .cmd_valid(cmd6_valid),
      .cmd_ready(cmd6_ready), .done(done6), .pending(pending6),
      .overflow(overflow6), .bad_index(bad6), .timeout(timeout6)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   // Monitor: command handshakes are compared against the scoreboard.
   always @(negedge clk) begin
      hs_pending = cmd_valid && cmd_ready;
      if (hs_pending) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL grant: got unexpected cmd_index %0d, expected none", cmd_index);
         end else begin
            chk("grant", int'(cmd_index), exp_q.pop_front());
         end
      end
      if (overflow)  ov_cnt++;
      if (timeout)   to_cnt++;
      if (bad6)      bad6_cnt++;
   end

   // Resource model: done in the first WAIT_DONE cycle when auto_en is set.
   initial begin
      done = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         done = (auto_en && hs_pending) || man_done;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_ev(input int idx);
      ev_valid = 1'b1;
      ev_index = 3'(idx);
      tick(1);
      ev_valid = 1'b0;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      tick(2);
      rstn = 1'b1;
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || pending != 8'h00 || cmd_valid) && n < budget) begin
         tick(1);
         n++;
      end
      chk(name, (exp_q.size() == 0 && pending == 8'h00 && !cmd_valid) ? 1 : 0, 1);
   endtask

   initial begin
      int ov_base;
      rstn = 1'b1;
      ev_valid = 1'b0; ev_index = 3'd0; cmd_ready = 1'b0;
      ev6_valid = 1'b0; ev6_index = 3'd0; cmd6_ready = 1'b1; done6 = 1'b0;
      #1 rstn = 1'b0;
      #2;
      // reset state
      chk("rst_ev_ready",  int'(ev_ready), 0);
      chk("rst_cmd_valid", int'(cmd_valid), 0);
      chk("rst_cmd_index", int'(cmd_index), 0);
      chk("rst_pending",   int'(pending), 0);
      chk("rst_pulses",    int'({overflow, bad_index, timeout}), 0);
      tick(2);
      rstn = 1'b1;
      chk("ev_ready_up", int'(ev_ready), 1);

      // single event on channel 3, 3-cycle command
      auto_en = 1'b1; cmd_ready = 1'b1;
      exp_q.push_back(3);
      send_ev(3);
      chk("t1_pend_set", int'(pending), 8'h08);
      chk("t1_no_cmd_yet", int'(cmd_valid), 0);
      tick(1);
      chk("t1_cmd_valid", int'(cmd_valid), 1);
      chk("t1_cmd_index", int'(cmd_index), 3);
      tick(1);
      chk("t1_wait_pend", int'(pending), 8'h08);
      chk("t1_wait_novalid", int'(cmd_valid), 0);
      tick(1);
      chk("t1_pend_clr", int'(pending), 0);

      // round-robin order from ptr 0 with channel 0 holding the resource
      do_reset();
      cmd_ready = 1'b0;
      exp_q.push_back(0);
      send_ev(0);
      exp_q.push_back(1); exp_q.push_back(5); exp_q.push_back(6);
      send_ev(5); send_ev(1); send_ev(6);
      tick(2);
      chk("t2_issue_hold_v", int'(cmd_valid), 1);
      chk("t2_issue_hold_i", int'(cmd_index), 0);
      chk("t2_pend", int'(pending), 8'h63);
      cmd_ready = 1'b1;
      drain("t2_drain", 100);
      exp_q.push_back(0);
      send_ev(0);
      drain("t2_wrap_drain", 50);

      // saturation: 16 events then one more, then cancel on same edge
      do_reset();
      cmd_ready = 1'b0;
      ov_base = ov_cnt;
      exp_q.push_back(2);
      ev_valid = 1'b1; ev_index = 3'd2;
      tick(16);
      ev_valid = 1'b0;
      tick(2);
      chk("t3_ovf_once", ov_cnt - ov_base, 1);
      send_ev(2);
      tick(2);
      chk("t3_ovf_twice", ov_cnt - ov_base, 2);
      auto_en = 1'b0; cmd_ready = 1'b1;
      tick(1);
      cmd_ready = 1'b0;
      man_done = 1'b1; ev_valid = 1'b1; ev_index = 3'd2;
      tick(1);
      man_done = 1'b0; ev_valid = 1'b0;
      tick(2);
      chk("t3_no_ovf_on_cancel", ov_cnt - ov_base, 2);
      for (int i = 0; i < 15; i++) exp_q.push_back(2);
      auto_en = 1'b1; cmd_ready = 1'b1;
      drain("t3_drain15", 200);

      // out-of-range index on the 6-channel instance
      ev6_valid = 1'b1; ev6_index = 3'd7;
      tick(1);
      ev6_index = 3'd6;
      tick(1);
      ev6_valid = 1'b0;
      tick(2);
      chk("t4_bad_pulses", bad6_cnt, 2);
      chk("t4_pend6", int'(pending6), 0);
      chk("t4_cmd6_valid", int'(cmd6_valid), 0);
      ev6_valid = 1'b1; ev6_index = 3'd5;
      tick(1);
      ev6_valid = 1'b0;
      chk("t4_pend6_ok", int'(pending6), 6'h20);
      chk("t4_bad_still", bad6_cnt, 2);

      // watchdog
      do_reset();
      auto_en = 1'b0; cmd_ready = 1'b1;
      exp_q.push_back(4);
      send_ev(4);
      tick(1);
      chk("t5_cmd_valid", int'(cmd_valid), 1);
      tick(1);
      cmd_ready = 1'b0;
      chk("t5_in_wait", int'(cmd_valid), 0);
`ifdef RR_EVENT_DISPATCHER_TIMEOUT_EN
      tick(9);
      chk("t5_no_to_yet", int'(timeout), 0);
      chk("t5_pend_held", int'(pending), 8'h10);
      tick(1);
      chk("t5_timeout", int'(timeout), 1);
      chk("t5_pend_dec", int'(pending), 0);
      tick(1);
      chk("t5_to_single", int'(timeout), 0);
`else
      tick(1000);
      chk("t5_still_wait", int'(pending), 8'h10);
      chk("t5_no_timeout", to_cnt, 0);
      chk("t5_no_reissue", int'(cmd_valid), 0);
      man_done = 1'b1;
      tick(1);
      man_done = 1'b0;
      chk("t5_done_dec", int'(pending), 0);
`endif

      // asynchronous reset while in WAIT_DONE
      do_reset();
      auto_en = 1'b0; cmd_ready = 1'b1;
      exp_q.push_back(3);
      send_ev(3);
      send_ev(3);
      tick(1);
      cmd_ready = 1'b0;
      chk("t6_pend_before", int'(pending), 8'h08);
      rstn = 1'b0;
      #1;
      chk("t6_async_ready", int'(ev_ready), 0);
      chk("t6_async_pend", int'(pending), 0);
      chk("t6_async_index", int'(cmd_index), 0);
      chk("t6_async_valid", int'(cmd_valid), 0);
      tick(2);
      rstn = 1'b1;
      man_done = 1'b1;
      tick(1);
      man_done = 1'b0;
      tick(3);
      chk("t6_late_done_pend", int'(pending), 0);
      chk("t6_late_done_valid", int'(cmd_valid), 0);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
